// File: rtl/lpdaq_pkg.sv
// Shared LPDAQ constants: default stream width, default buffer address width,
// and the occupancy width also used by the AXI4-Lite register block.
package lpdaq_pkg;

  localparam int LPDAQ_AXIS_DW  = 24;
  localparam int LPDAQ_AW       = 10;
  localparam int LPDAQ_RD_CNT_W = 32;

  typedef logic [LPDAQ_RD_CNT_W-1:0] lpdaq_rd_cnt_t;

endpackage

// File: rtl/lpdaq_axis_sample_fifo_if.sv
// AXI-Stream data/handshake bundle used on both sides of the sample FIFO.
interface lpdaq_axis_sample_fifo_if #(
  parameter int DW = 24
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/lpdaq_sdp_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// read enable. The read register doubles as the FIFO head-sample register,
// so it holds its value whenever re is low.
module lpdaq_sdp_ram #(
  parameter int DW = 24,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rdata_r;

  // Storage array write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; holds the last value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/lpdaq_axis_sample_fifo.sv
// LPDAQ sample buffer: 2**AW RAM entries plus the RAM read register acting as
// the output stage (capacity 2**AW+1). Reports occupancy and a saturating
// count of samples lost while full.
module lpdaq_axis_sample_fifo
  import lpdaq_pkg::*;
#(
  parameter int AXIS_DW = LPDAQ_AXIS_DW,
  parameter int AW      = LPDAQ_AW,
  parameter int OVF_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  lpdaq_axis_sample_fifo_if.slave        s_axis,
  lpdaq_axis_sample_fifo_if.master       m_axis,
  output lpdaq_rd_cnt_t                  rd_cnt,
  output logic [OVF_W-1:0]               ovf_cnt
);

  localparam logic [AW:0]      ZERO_CNT = {(AW+1){1'b0}};
  localparam logic [AW:0]      ONE_CNT  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0]    ZERO_PTR = {AW{1'b0}};
  localparam logic [AW-1:0]    ONE_PTR  = AW'(1'b1);
  localparam logic [OVF_W-1:0] OVF_ZERO = {OVF_W{1'b0}};
  localparam logic [OVF_W-1:0] OVF_ONE  = OVF_W'(1'b1);
  localparam logic [OVF_W-1:0] OVF_MAX  = {OVF_W{1'b1}};

  logic [AW-1:0]      wptr_r;
  logic [AW-1:0]      rptr_r;
  logic [AW:0]        mem_cnt_r;
  logic [AW:0]        mem_cnt_next_s;
  logic               ready_r;
  logic               m_valid_r;
  lpdaq_rd_cnt_t      rd_cnt_r;
  logic [OVF_W-1:0]   ovf_cnt_r;
  logic               ready_s;
  logic               wr_s;
  logic               load_s;
  logic [AXIS_DW-1:0] rd_data_s;

  // ready_r is a registered "not full" flag; it is low in reset so the input
  // only opens on the first edge after release.
  assign ready_s = ready_r && !flush;
  assign wr_s    = s_axis.tvalid && ready_s;
  // mem_cnt_r != 0 guarantees the read address never equals this cycle's
  // write address, so no read-during-write behaviour is relied on.
  assign load_s  = (!m_valid_r || m_axis.tready) && (mem_cnt_r != ZERO_CNT) && !flush;

  // Next RAM occupancy from write/load events, flush forcing empty.
  always_comb begin
    mem_cnt_next_s = mem_cnt_r;
    if (flush) begin
      mem_cnt_next_s = ZERO_CNT;
    end else begin
      case ({wr_s, load_s})
        2'b10:   mem_cnt_next_s = mem_cnt_r + ONE_CNT;
        2'b01:   mem_cnt_next_s = mem_cnt_r - ONE_CNT;
        default: mem_cnt_next_s = mem_cnt_r;
      endcase
    end
  end

  // Write/read pointers, wrapping naturally at 2**AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= ZERO_PTR;
      rptr_r <= ZERO_PTR;
    end else if (flush) begin
      wptr_r <= ZERO_PTR;
      rptr_r <= ZERO_PTR;
    end else begin
      wptr_r <= wr_s   ? wptr_r + ONE_PTR : wptr_r;
      rptr_r <= load_s ? rptr_r + ONE_PTR : rptr_r;
    end
  end

  // Occupancy and input-ready flag; ready follows the post-edge count, so a
  // full buffer that loads this cycle reopens one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt_r <= ZERO_CNT;
      ready_r   <= 1'b0;
    end else begin
      mem_cnt_r <= mem_cnt_next_s;
      ready_r   <= (mem_cnt_next_s != FULL_CNT);
    end
  end

  // Output-valid flag for the head sample held in the RAM read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
    end else if (flush) begin
      m_valid_r <= 1'b0;
    end else if (load_s) begin
      m_valid_r <= 1'b1;
    end else if (m_axis.tready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  // Registered occupancy seen by software, one cycle behind the handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_r <= {LPDAQ_RD_CNT_W{1'b0}};
    end else if (flush) begin
      rd_cnt_r <= {LPDAQ_RD_CNT_W{1'b0}};
    end else begin
      rd_cnt_r <= LPDAQ_RD_CNT_W'(mem_cnt_r) + LPDAQ_RD_CNT_W'(m_valid_r);
    end
  end

  // Saturating count of samples offered while the buffer could not take them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_r <= OVF_ZERO;
    end else if (flush) begin
      ovf_cnt_r <= OVF_ZERO;
    end else if (s_axis.tvalid && !ready_r && (ovf_cnt_r != OVF_MAX)) begin
      ovf_cnt_r <= ovf_cnt_r + OVF_ONE;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

  lpdaq_sdp_ram #(
    .DW (AXIS_DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_s),
    .waddr (wptr_r),
    .wdata (s_axis.tdata),
    .re    (load_s),
    .raddr (rptr_r),
    .rdata (rd_data_s)
  );

  assign s_axis.tready = ready_s;
  assign m_axis.tvalid = m_valid_r;
  assign m_axis.tdata  = rd_data_s;
  assign rd_cnt        = rd_cnt_r;
  assign ovf_cnt       = ovf_cnt_r;

endmodule

// File: doc/lpdaq_axis_sample_fifo.md
# lpdaq_axis_sample_fifo

Synchronous sample buffer for the LPDAQ acquisition path. It sits directly upstream of the AXI4-Lite stream-FIFO read interface. It accepts 24-bit samples from the ADC capture stage on an AXI-Stream slave port and presents them to the register interface on an AXI-Stream master port. It also reports the live occupancy (`rd_cnt`) so software can size its burst reads, and counts samples dropped on overflow.

## Interface
- `AXIS_DW`, 24, sample width in bits.
- `AW`, 10, memory address width; memory depth is 2**AW.
- `OVF_W`, 16, width of the saturating overflow counter.

- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- `flush`  in  1  synchronous clear of all stored samples and of `ovf_cnt`.
- `s_axis_tdata`  in  AXIS_DW  sample from the capture stage.
- `s_axis_tvalid`  in  1  sample valid.
- `s_axis_tready`  out  1  buffer can accept a sample.
- `m_axis_tdata`  out  AXIS_DW  sample to the AXI4-Lite read interface.
- `m_axis_tvalid`  out  1  output sample valid.
- `m_axis_tready`  in  1  consumer accepts the sample.
- `rd_cnt`  out  32  samples available to the consumer, zero-extended.
- `ovf_cnt`  out  OVF_W  saturating count of rejected samples.

## Operation
- **Storage:** 2**AW-entry simple dual-port RAM plus one output register holding the head sample. Total capacity is 2**AW+1.
- **Pointers and count:** `wptr` and `rptr` are AW bits and wrap modulo 2**AW naturally. `mem_cnt` is AW+1 bits, range 0..2**AW.
- **Input side:**
  - `s_axis_tready = (mem_cnt != 2**AW) && !flush`, registered-state only, with no combinational path from `m_axis_tready`.
  - Write fires on `s_axis_tvalid && s_axis_tready`. The RAM is written at `wptr`, then `wptr` increments.
- **Overflow:**
  - Every cycle with `s_axis_tvalid && !s_axis_tready && !flush` increments `ovf_cnt`.
  - The counter saturates at all-ones and never wraps.
  - The capture stage cannot stall, so a rejected sample is lost.
- **Output side:**
  - Define `load = (!m_axis_tvalid || m_axis_tready) && mem_cnt != 0`.
  - On `load`, the RAM registered read at `rptr` fills `m_axis_tdata`, `m_axis_tvalid` is set, and `rptr` increments.
  - If the consumer accepts the sample and there is no `load`, `m_axis_tvalid` clears.
  - `m_axis_tdata` is held stable while `m_axis_tvalid && !m_axis_tready`.
- **Count update:** `mem_cnt` next value is `mem_cnt + write - load`. A simultaneous write and load leaves it unchanged.
- **`rd_cnt`:** equals `mem_cnt + m_axis_tvalid`, registered, zero-extended to 32 bits.
- **`flush`:**
  - Clears `wptr`, `rptr`, `mem_cnt`, `m_axis_tvalid`, `rd_cnt` and `ovf_cnt` on the next edge.
  - A sample presented in the `flush` cycle is neither written nor counted as overflow.
  - `flush` has priority over all other events.
- **Reset:** `rst_n` low clears everything asynchronously.
  - Outputs under reset: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `rd_cnt`=0, `ovf_cnt`=0.
  - Reset mid-transfer discards all contents.
  - `s_axis_tready` rises on the first edge after deassertion.

## Timing
- **Latency:** a write into a completely empty buffer at edge N is visible as `m_axis_tvalid`=1 after edge N+1, i.e. 2-cycle input-to-output latency.
- **Throughput:** one sample per cycle in and out, sustained, with no bubbles when `mem_cnt` > 0 and `m_axis_tready` is held high.
- **Read/write collision:** reading and writing the same RAM address in one cycle cannot occur, because `load` requires `mem_cnt` != 0 from the previous edge.
- **Full with read:** when the memory is full and a load occurs in the same cycle, the input write is still refused. `s_axis_tready` reflects the pre-edge state and rises one cycle later.
- **Count lag:** `rd_cnt` lags the handshakes by one cycle.

## Structure
- Shared package/include `lpdaq_pkg`: default `AXIS_DW`, default `AW`, and the `rd_cnt` width constant (32), shared with the AXI4-Lite interface block.
- One sub-module, `lpdaq_sdp_ram`: simple dual-port RAM with a synchronous write port and a registered read with read enable, inferable as block RAM.
- Pointer, count, overflow and output-register logic stay in the top block.

## Test plan
- **Single sample:** after reset, write one sample 0x123456 with `m_axis_tready`=0.
  - `m_axis_tvalid`=1 with data 0x123456 two edges later.
  - `rd_cnt`=1.
  - Data stays stable until `m_axis_tready`=1, then `rd_cnt`=0.
- **Fill to capacity:** with AW=3 and `m_axis_tready`=0, stream 12 samples 1..12.
  - Samples 1..9 are accepted and `rd_cnt`=9.
  - `s_axis_tready`=0 from the 10th.
  - `ovf_cnt`=3.
  - Draining returns 1..9 in order.
- **Streaming:** with `m_axis_tready`=1, stream 1000 incrementing samples with no bubbles.
  - Output is in order with no gaps after the 2-cycle fill.
  - `rd_cnt` stays at ≤2.
  - Pointers wrap correctly.
- **Flush:** with the buffer half full, assert `flush` for one cycle.
  - Next edge: `rd_cnt`=0, `m_axis_tvalid`=0, `ovf_cnt`=0.
  - Subsequent samples emerge first, with no stale data.
- **Reset and saturation:**
  - Assert `rst_n` low mid-stream: all outputs go to 0 immediately, and after release the first sample written is the first read.
  - With OVF_W=4, force 20 overflow cycles: `ovf_cnt` holds at 15.
